// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory RAM between the CPU (port 0) and a DMA/debug port (port 1).
// Port 1 may hold a bounded burst lock. Optional stall statistic: define ARB_STATS_EN.
module dmem_arbiter #(
  parameter int DBITS        = 32,
  parameter int DMEMADDRBITS = 16,
  parameter int DMEMWORDBITS = 2,
  parameter int MAXBURST     = 8
) (
  input  logic                                 clk,
  input  logic                                 RESET_N,
  input  logic                                 req0,
  input  logic                                 we0,
  input  logic [DBITS-1:0]                     addr0,
  input  logic [DBITS-1:0]                     wdata0,
  output logic                                 gnt0,
  output logic                                 rvalid0,
  output logic [DBITS-1:0]                     rdata0,
  input  logic                                 req1,
  input  logic                                 we1,
  input  logic [DBITS-1:0]                     addr1,
  input  logic [DBITS-1:0]                     wdata1,
  output logic                                 gnt1,
  output logic                                 rvalid1,
  output logic [DBITS-1:0]                     rdata1,
  input  logic                                 lock1,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
  output logic                                 mem_we,
  output logic [DBITS-1:0]                     mem_wdata,
  input  logic [DBITS-1:0]                     mem_rdata,
  output logic [15:0]                          stall0_cnt
);

  localparam logic [7:0]       MAXB     = 8'(MAXBURST);
  localparam logic [DBITS-1:0] OOR_DATA = DBITS'(32'hDEADDEAD);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t     state, state_nx;
  logic       ptr, ptr_nx;
  logic       inhibit, inhibit_nx;
  logic [7:0] count, count_nx;
  logic       arb_ptr;
  logic       in0, in1;
  logic       oor0, oor1;
  logic       unused_addr_bits;

  assign in0 = (addr0[DBITS-1:DMEMADDRBITS] == '0);
  assign in1 = (addr1[DBITS-1:DMEMADDRBITS] == '0);
  assign unused_addr_bits = ^{addr0[DMEMWORDBITS-1:0], addr1[DMEMWORDBITS-1:0]};

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      ptr     <= 1'b0;
      inhibit <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      inhibit <= inhibit_nx;
      count   <= count_nx;
    end
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    arb_ptr    = ptr;
    state_nx   = state;
    ptr_nx     = ptr;
    count_nx   = count;
    inhibit_nx = inhibit & lock1;
    if (RESET_N) begin
      if (state == ST_LOCKED && lock1) begin
        gnt1 = req1;
        if (req1) begin
          count_nx = count + 8'd1;
          if (count_nx == MAXB) begin
            state_nx   = ST_IDLE;
            ptr_nx     = 1'b0;
            inhibit_nx = 1'b1;
            count_nx   = '0;
          end
        end
      end else begin
        // Leaving a burst by dropping lock1 arbitrates this same cycle with port 0 favoured.
        arb_ptr = (state == ST_LOCKED) ? 1'b0 : ptr;
        if (req0 && (!req1 || !arb_ptr)) gnt0 = 1'b1;
        else if (req1)                   gnt1 = 1'b1;
        if (gnt0)      ptr_nx = 1'b1;
        else if (gnt1) ptr_nx = 1'b0;
        state_nx = ST_IDLE;
        count_nx = '0;
        if (gnt1 && lock1 && !inhibit) begin
          state_nx = ST_LOCKED;
          count_nx = 8'd1;
        end
      end
    end
  end

  assign mem_addr  = gnt1 ? addr1[DMEMADDRBITS-1:DMEMWORDBITS] : addr0[DMEMADDRBITS-1:DMEMWORDBITS];
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign mem_we    = (gnt0 & we0 & in0) | (gnt1 & we1 & in1);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      oor0    <= 1'b0;
      oor1    <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      oor0    <= ~in0;
      oor1    <= ~in1;
    end
  end

  assign rdata0 = rvalid0 ? (oor0 ? OOR_DATA : mem_rdata) : '0;
  assign rdata1 = rvalid1 ? (oor1 ? OOR_DATA : mem_rdata) : '0;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N)                                 stall0_cnt <= '0;
    else if (req0 && !gnt0 && stall0_cnt != '1)   stall0_cnt <= stall0_cnt + 16'd1;
  end
`else
  assign stall0_cnt = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data-memory RAM between the CPU memory stage (port 0) and a DMA/debug requester (port 1). It does round-robin arbitration with a bounded burst lock for port 1. It drives a synchronous-read RAM with one-cycle read latency and returns read data to the granted requester. MMIO decode (HEX/LEDR/KEY/SW) stays outside this block; it sees only the RAM address space.

Parameters:
DBITS, 32, data and address width
DMEMADDRBITS, 16, byte-address bits decoded as RAM
DMEMWORDBITS, 2, byte-offset bits dropped to form the word index
MAXBURST, 8, maximum consecutive locked beats for port 1 (2..255)

Ports:
clk  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0
we0  in  1  port 0 write (1) / read (0)
addr0  in  DBITS  port 0 byte address
wdata0  in  DBITS  port 0 write data
gnt0  out  1  port 0 access accepted this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DBITS  port 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
lock1  in  1  port 1 burst lock request
mem_addr  out  DMEMADDRBITS-DMEMWORDBITS  RAM word index
mem_we  out  1  RAM write enable
mem_wdata  out  DBITS  RAM write data
mem_rdata  in  DBITS  RAM read data, valid the cycle after the address
stall0_cnt  out  16  port 0 stall statistic (see Optional Feature)

Behaviour:
- Reset (RESET_N low, async): state IDLE, ptr=0, beat count=0, relock inhibit=0, rvalid0/1=0, stall0_cnt=0. gnt0/gnt1/mem_we are forced 0 while reset is asserted.
- Grants are combinational from req and registered state. At most one of gnt0/gnt1 is high per cycle. A granted access completes in 1 cycle.
- IDLE arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port equal to ptr is granted.
  - ptr <= the other port after every grant.
- mem_addr, mem_we and mem_wdata come from the granted port.
  - mem_addr = addr[DMEMADDRBITS-1:DMEMWORDBITS].
  - mem_we = gnt & we & in_range, where in_range means addr[DBITS-1:DMEMADDRBITS]==0.
  - With no grant, mem_we=0 and mem_addr/mem_wdata are don't-care.
- Read return:
  - rvalidX <= gntX & ~weX, so it is high exactly 1 cycle after a read grant.
  - rdataX = mem_rdata while rvalidX, else 0.
  - An out-of-range read is still granted, returns 32'hDEADDEAD, and performs no RAM access side effects.
  - An out-of-range write is granted and dropped.
- Lock state machine, states IDLE and LOCKED:
  - IDLE->LOCKED: at an edge where gnt1 & lock1 & ~inhibit. Set count=1.
  - In LOCKED: gnt1=req1 and gnt0=0. count increments on each gnt1. ptr is not updated.
  - LOCKED->IDLE when lock1 is low. In the cycle lock1 is seen low, arbitration is already the IDLE rule with ptr=0.
  - LOCKED->IDLE when a grant makes count==MAXBURST. This forced release sets ptr=0 and inhibit=1.
  - inhibit clears at the first edge with lock1 low. While inhibit=1, port 1 is arbitrated as in IDLE.
- Reset mid-burst or mid-read: lock is dropped and pending rvalid is cleared. No spurious rvalid after reset release.

Optional Feature:
ARB_STATS_EN:
- Defined: stall0_cnt increments on each cycle with req0 & ~gnt0, saturates at 16'hFFFF, and clears on reset.
- Undefined: stall0_cnt is tied to 0 and no counter logic is built.

Test Plan:
1. req0 read addr0=0x40 alone, RAM[0x10]=0x1234 -> gnt0 same cycle, mem_addr=0x10, next cycle rvalid0=1, rdata0=0x1234; rvalid1 stays 0.
2. req0 and req1 writes held together after reset -> gnt0 cycle 1, gnt1 cycle 2, never both high. Repeat with both held 4 cycles -> grants alternate 0,1,0,1.
3. port1 lock1=1, req1 held, req0 held, MAXBURST=8 -> 8 consecutive gnt1, then gnt0 on the next cycle. gnt1 does not lock again until lock1 drops for 1 cycle.
4. port1 locks, 3 beats, lock1 drops -> gnt0 same cycle lock1 is low; the state machine reads IDLE next edge.
5. write addr1=0xFFFFF000 data 0xABCD -> gnt1=1, mem_we=0. A read of 0xFFFFF000 -> rvalid1 with rdata1=0xDEADDEAD.
6. RESET_N pulsed low during a locked burst with a read just granted -> gnt0/gnt1/mem_we low immediately, rvalid cleared. After release, normal arbitration with ptr=0. With ARB_STATS_EN, stall0_cnt reads 0 after reset and counts 8 during scenario 3.
